// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg
//   Shared definitions for the accumulator CPU control unit: opcodes,
//   SKIPCOND condition codes, ALU mode encodings and the sequencer state
//   enumeration. Imported by acc_cpu_ctrl_decode and acc_cpu_control_unit.
package acc_cpu_pkg;

  // Opcodes live in IR[31:28]; 0x8-0xE are undefined.
  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_STORE    = 4'h2;
  localparam logic [3:0] OP_ADD      = 4'h3;
  localparam logic [3:0] OP_SUB      = 4'h4;
  localparam logic [3:0] OP_SKIPCOND = 4'h5;
  localparam logic [3:0] OP_JUMP     = 4'h6;
  localparam logic [3:0] OP_CLEAR    = 4'h7;
  localparam logic [3:0] OP_HALT     = 4'hF;

  // SKIPCOND condition field (IR[27:26]); AC is compared as signed.
  localparam logic [1:0] SKIP_LT    = 2'b00;
  localparam logic [1:0] SKIP_EQ    = 2'b01;
  localparam logic [1:0] SKIP_GT    = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  // ALU mode encodings.
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;

  typedef enum logic [3:0] {
    IDLE,
    F0,
    F1,
    F2,
    DECODE,
    E0,
    E1,
    E2,
    E3,
    HALTED
  } state_t;

  // True when the opcode names a defined instruction.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_CLEAR) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/acc_cpu_ctrl_decode.sv
// acc_cpu_ctrl_decode
//   Combinational control decode for the accumulator CPU sequencer.
//   Ports:
//     state       in   current sequencer state
//     opcode      in   IR[31:28]
//     start       in   start request (only honoured in IDLE / HALTED)
//     state_next  out  next sequencer state
//     mem_cs/we/oe out RAM strobes
//     alu_sel     out  ALU mode
//     instr_done  out  last cycle of a retired instruction
//     illegal_hit out  undefined opcode reached E0 this cycle
module acc_cpu_ctrl_decode
  import acc_cpu_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       start,
  output state_t     state_next,
  output logic       mem_cs,
  output logic       mem_we,
  output logic       mem_oe,
  output logic [3:0] alu_sel,
  output logic       instr_done,
  output logic       illegal_hit
);

  always_comb begin
    state_next  = state;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    mem_oe      = 1'b0;
    alu_sel     = ALU_NONE;
    instr_done  = 1'b0;
    illegal_hit = 1'b0;

    case (state)
      IDLE, HALTED: begin
        if (start) state_next = F0;
      end
      F0:     state_next = F1;
      F1: begin
        mem_cs     = 1'b1;
        mem_oe     = 1'b1;
        state_next = F2;
      end
      F2:     state_next = DECODE;
      DECODE: state_next = E0;
      E0: begin
        if (!op_is_legal(opcode)) begin
          // Undefined opcode: stop without retiring the instruction.
          illegal_hit = 1'b1;
          state_next  = HALTED;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_next = E1;
            OP_HALT: begin
              instr_done = 1'b1;
              state_next = HALTED;
            end
            default: begin
              // NOP, SKIPCOND, JUMP, CLEAR finish in E0.
              instr_done = 1'b1;
              state_next = F0;
            end
          endcase
        end
      end
      E1: begin
        mem_cs = 1'b1;
        if (opcode == OP_STORE) begin
          mem_we     = 1'b1;
          instr_done = 1'b1;
          state_next = F0;
        end else begin
          mem_oe     = 1'b1;
          state_next = E2;
        end
      end
      E2:     state_next = E3;
      E3: begin
        instr_done = 1'b1;
        state_next = F0;
        if (opcode == OP_ADD)      alu_sel = ALU_ADD;
        else if (opcode == OP_SUB) alu_sel = ALU_SUB;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/acc_cpu_control_unit.sv
// acc_cpu_control_unit
//   Multicycle fetch/decode/execute sequencer for the 32-bit accumulator
//   CPU. Holds PC, IR, MAR, MBR and AC; drives a single-port synchronous
//   RAM (one-cycle read latency) and a combinational ALU.
//   Ports:
//     clock, reset_n        clock (rising edge), async active-low reset
//     start                 begin execution at RESET_PC (IDLE/HALTED only)
//     mem_cs/we/oe          RAM strobes, decoded from state
//     mem_addr / mem_wdata  MAR / MBR
//     mem_rdata             RAM read data, one cycle after cs&oe
//     alu_left / alu_right  AC / MBR
//     alu_sel / alu_out     ALU mode and result
//     running, halted       status
//     illegal_op            sticky undefined-opcode flag
//     instr_done            pulse on the last cycle of a retired instruction
//     pc_out, ac_out        debug views of PC and AC
module acc_cpu_control_unit
  import acc_cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 28,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] alu_left,
  output logic [DATA_WIDTH-1:0] alu_right,
  output logic [3:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  running,
  output logic                  halted,
  output logic                  illegal_op,
  output logic                  instr_done,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ac_out
);

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg;
  logic [DATA_WIDTH-1:0]   ir_reg;
  logic [ADDR_WIDTH-1:0]   mar_reg;
  logic [DATA_WIDTH-1:0]   mbr_reg;
  logic [DATA_WIDTH-1:0]   ac_reg;
  logic                    illegal_reg;
  logic                    illegal_hit;

  logic [3:0]              opcode;
  logic [ADDR_WIDTH-1:0]   operand;
  logic [1:0]              skip_code;
  logic                    skip_taken;
  logic [ADDR_WIDTH-1:0]   pc_inc;

  assign opcode    = ir_reg[DATA_WIDTH-1 -: 4];
  assign operand   = ir_reg[ADDR_WIDTH-1:0];
  assign skip_code = ir_reg[ADDR_WIDTH-1 -: 2];
  assign pc_inc    = pc_reg + ADDR_WIDTH'(1);  // wraps mod 2^ADDR_WIDTH

  // Signed test of AC: sign bit gives negative, zero check gives equal.
  always_comb begin
    skip_taken = 1'b0;
    case (skip_code)
      SKIP_LT: skip_taken = ac_reg[DATA_WIDTH-1];
      SKIP_EQ: skip_taken = (ac_reg == '0);
      SKIP_GT: skip_taken = !ac_reg[DATA_WIDTH-1] && (ac_reg != '0);
      default: skip_taken = 1'b0;
    endcase
  end

  acc_cpu_ctrl_decode u_decode (
    .state       (state_reg),
    .opcode      (opcode),
    .start       (start),
    .state_next  (state_next),
    .mem_cs      (mem_cs),
    .mem_we      (mem_we),
    .mem_oe      (mem_oe),
    .alu_sel     (alu_sel),
    .instr_done  (instr_done),
    .illegal_hit (illegal_hit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      mar_reg     <= '0;
      mbr_reg     <= '0;
      ac_reg      <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (illegal_hit) illegal_reg <= 1'b1;
      case (state_reg)
        IDLE, HALTED: begin
          if (start) begin
            pc_reg      <= RESET_PC;
            ac_reg      <= '0;
            illegal_reg <= 1'b0;
          end
        end
        F0: mar_reg <= pc_reg;
        F2: begin
          ir_reg <= mem_rdata;
          pc_reg <= pc_inc;
        end
        E0: begin
          case (opcode)
            OP_LOAD, OP_ADD, OP_SUB: mar_reg <= operand;
            OP_STORE: begin
              mar_reg <= operand;
              mbr_reg <= ac_reg;
            end
            OP_SKIPCOND: if (skip_taken) pc_reg <= pc_inc;
            OP_JUMP:     pc_reg <= operand;
            OP_CLEAR:    ac_reg <= '0;
            default:     ;
          endcase
        end
        // Only the read-type instructions reach E2/E3.
        E2: mbr_reg <= mem_rdata;
        E3: ac_reg  <= (opcode == OP_LOAD) ? mbr_reg : alu_out;
        default: ;
      endcase
    end
  end

  assign mem_addr   = mar_reg;
  assign mem_wdata  = mbr_reg;
  assign alu_left   = ac_reg;
  assign alu_right  = mbr_reg;
  assign running    = (state_reg != IDLE) && (state_reg != HALTED);
  assign halted     = (state_reg == HALTED);
  assign illegal_op = illegal_reg;
  assign pc_out     = pc_reg;
  assign ac_out     = ac_reg;

endmodule

// File: tb/tb_acc_cpu_control_unit.sv
module tb_acc_cpu_control_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mem_cs, mem_we, mem_oe;
  logic [27:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] alu_left, alu_right, alu_out;
  logic [3:0]  alu_sel;
  logic        running, halted, illegal_op, instr_done;
  logic [27:0] pc_out;
  logic [31:0] ac_out;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit done_seen = 0;

  typedef struct { logic [27:0] pc; logic [31:0] ac; } instr_exp_t;
  typedef struct { logic [27:0] addr; logic [31:0] data; } wr_exp_t;
  instr_exp_t sb_q[$];
  wr_exp_t    wr_q[$];

  logic [31:0] mem [0:4095];

  always #5 clock = ~clock;

  acc_cpu_control_unit dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .alu_left   (alu_left),
    .alu_right  (alu_right),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .running    (running),
    .halted     (halted),
    .illegal_op (illegal_op),
    .instr_done (instr_done),
    .pc_out     (pc_out),
    .ac_out     (ac_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference ALU.
  always_comb begin
    alu_out = '0;
    if (alu_sel == 4'b0010)      alu_out = alu_left + alu_right;
    else if (alu_sel == 4'b0011) alu_out = alu_left - alu_right;
  end

  // Synchronous RAM model (12-bit index) with write scoreboard.
  always @(posedge clock) begin
    if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr[11:0]];
    if (mem_cs && mem_we) begin
      if (wr_q.size() == 0) begin
        check_eq("wr_unexpected", wr_q.size(), 1);
      end else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        $display("write addr=%h data=%h", mem_addr, mem_wdata);
        check_eq("wr_addr", {4'h0, mem_addr}, {4'h0, w.addr});
        check_eq("wr_data", mem_wdata, w.data);
      end
      mem[mem_addr[11:0]] = mem_wdata;
    end
  end

  // Instruction scoreboard: compare architectural state one cycle after
  // each instr_done pulse, once the final register update has landed.
  always @(negedge clock) begin
    if (done_seen) begin
      done_seen = 0;
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", sb_q.size(), 1);
      end else begin
        instr_exp_t e;
        e = sb_q.pop_front();
        $display("instr pc=%h ac=%h", pc_out, ac_out);
        check_eq("instr_pc", {4'h0, pc_out}, {4'h0, e.pc});
        check_eq("instr_ac", ac_out, e.ac);
      end
    end
    if (instr_done && reset_n) begin
      done_seen = 1;
      done_cnt++;
    end
  end

  task automatic poke(input int a, input logic [31:0] d);
    logic [31:0] av;
    av = a;
    mem[av[11:0]] = d;
  endtask

  task automatic expect_instr(input int pc, input logic [31:0] ac);
    instr_exp_t e;
    e.pc = pc[27:0];
    e.ac = ac;
    sb_q.push_back(e);
  endtask

  // Pulse start; cycles counts edges after the accept edge until halted.
  task automatic run_to_halt(output int cycles);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cycles = 0;
    while (!halted && cycles < 200) begin
      @(posedge clock);
      #1 cycles++;
    end
    check_eq("halt_reached", {31'b0, halted}, 1);
    repeat (2) @(negedge clock);
    check_eq("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    int cyc;
    int d0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

    // Reset with start held.
    reset_n = 1'b0;
    start   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_pc", {4'h0, pc_out}, 32'h100);
    check_eq("rst_strobes", {29'b0, mem_cs, mem_we, mem_oe}, 0);
    check_eq("rst_status", {28'b0, running, halted, illegal_op, instr_done}, 0);
    check_eq("rst_ac", ac_out, 0);
    check_eq("rst_addr", {4'h0, mem_addr}, 0);
    check_eq("rst_alu", alu_left | alu_right | {28'b0, alu_sel}, 0);
    start = 1'b0;
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1 check_eq("idle_wait", {31'b0, running}, 0);

    // LOAD / ADD / STORE / HALT.
    poke('h110, 5); poke('h111, 7);
    poke('h100, 32'h10000110); poke('h101, 32'h30000111);
    poke('h102, 32'h20000112); poke('h103, 32'hF0000000);
    expect_instr('h101, 5); expect_instr('h102, 12);
    expect_instr('h103, 12); expect_instr('h104, 12);
    begin
      wr_exp_t w;
      w.addr = 28'h112; w.data = 32'd12;
      wr_q.push_back(w);
    end
    d0 = done_cnt;
    run_to_halt(cyc);
    check_eq("halt_cycles", cyc, 27);
    check_eq("done_count", done_cnt - d0, 4);
    check_eq("mem_112", mem['h112], 12);
    check_eq("pc_final", {4'h0, pc_out}, 32'h104);
    check_eq("wr_drained", wr_q.size(), 0);

    // SUB / SKIPCOND / CLEAR / NOP.
    poke('h120, 3); poke('h121, 5);
    poke('h100, 32'h10000120); poke('h101, 32'h40000121);
    poke('h102, 32'h50000000); poke('h103, 32'h60000200);
    poke('h104, 32'h54000000); poke('h105, 32'h70000000);
    poke('h106, 32'h54000000); poke('h107, 32'h90000000);
    poke('h108, 32'h00000000); poke('h109, 32'hF0000000);
    expect_instr('h101, 3);
    expect_instr('h102, 32'hFFFFFFFE);
    expect_instr('h104, 32'hFFFFFFFE);
    expect_instr('h105, 32'hFFFFFFFE);
    expect_instr('h106, 0);
    expect_instr('h108, 0);
    expect_instr('h109, 0);
    expect_instr('h10A, 0);
    run_to_halt(cyc);
    check_eq("skip_illegal", {31'b0, illegal_op}, 0);

    // JUMP and PC wrap.
    poke('h100, 32'h6FFFFFFF); poke('hFFF, 32'h00000000); poke(0, 32'hF0000000);
    expect_instr('h0FFFFFFF, 0);
    expect_instr(0, 0);
    expect_instr(1, 0);
    run_to_halt(cyc);

    // Illegal opcode.
    poke('h100, 32'h10000120); poke('h101, 32'h90000000);
    expect_instr('h101, 3);
    d0 = done_cnt;
    run_to_halt(cyc);
    check_eq("illegal_set", {31'b0, illegal_op}, 1);
    check_eq("illegal_done", done_cnt - d0, 1);
    poke('h100, 32'hF0000000);
    expect_instr('h101, 0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check_eq("illegal_clr", {31'b0, illegal_op}, 0);
    check_eq("restart_pc", {4'h0, pc_out}, 32'h100);
    cyc = 0;
    while (!halted && cyc < 50) begin
      @(posedge clock);
      #1 cyc++;
    end
    check_eq("halt2", {31'b0, halted}, 1);
    repeat (2) @(negedge clock);

    // Async reset during STORE E1.
    poke('h130, 32'hDEAD);
    poke('h100, 32'h10000120); poke('h101, 32'h20000130);
    expect_instr('h101, 3);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 0;
    while (!mem_we && cyc < 50) begin
      @(posedge clock);
      #1 cyc++;
    end
    check_eq("store_we_seen", {31'b0, mem_we}, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_we_drop", {30'b0, mem_we, mem_cs}, 0);
    repeat (2) @(posedge clock);
    #1;
    check_eq("mem_130", mem['h130], 32'hDEAD);
    check_eq("rst2_pc", {4'h0, pc_out}, 32'h100);
    check_eq("rst2_run", {31'b0, running}, 0);
    check_eq("rst2_sb", sb_q.size(), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_cpu_control_unit.md
Name: acc_cpu_control_unit

Overview:
- Multicycle fetch/decode/execute sequencer for the 32-bit accumulator CPU.
- Owns PC, IR, MAR, MBR and AC.
- Sequences the single-port synchronous RAM (one-cycle read latency) and the combinational 32-bit ALU (left, right, alu_sel, alu_out).
- Replaces the hand-scheduled bench loop; sits between the top level, RAM and ALU.

Parameters:
- ADDR_WIDTH, 28, RAM word address width; equals IR operand field width.
- DATA_WIDTH, 32, word width. Opcode is bits [31:28].
- RESET_PC, 'h100, PC value loaded on start.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution from RESET_PC; sampled only in IDLE or HALTED.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_oe  out  1  RAM output enable.
- mem_addr  out  ADDR_WIDTH  RAM address (= MAR).
- mem_wdata  out  DATA_WIDTH  write data (= MBR); top level drives the bidir bus when mem_oe=0.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after cs&oe.
- alu_left  out  DATA_WIDTH  = AC.
- alu_right  out  DATA_WIDTH  = MBR.
- alu_sel  out  4  ALU mode.
- alu_out  in  DATA_WIDTH  ALU result.
- running  out  1  high outside IDLE and HALTED.
- halted  out  1  high in HALTED.
- illegal_op  out  1  sticky; set when HALTED was entered via an undefined opcode.
- instr_done  out  1  one-cycle pulse on the final cycle of every retired instruction, including HALT.
- pc_out  out  ADDR_WIDTH  current PC (debug).
- ac_out  out  DATA_WIDTH  current AC (debug).

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - PC=RESET_PC; IR, MAR, MBR, AC=0.
  - All outputs 0, except pc_out=RESET_PC.
- Memory strobes and alu_sel are combinational decodes of state only. They are 0 in every state not listed below; alu_sel defaults to 0.
- IDLE / HALTED with start=1:
  - PC<=RESET_PC, AC<=0, illegal_op<=0, go to F0.
  - start is ignored in all other states.
- Fetch (3 cycles):
  - F0: MAR<=PC.
  - F1: cs=1, oe=1.
  - F2: IR<=mem_rdata, PC<=PC+1 (mod 2^ADDR_WIDTH).
- DECODE (1 cycle): branch on IR[31:28].
- Execute:
  - 0x0 NOP: E0 no-op.
  - 0x1 LOAD: E0 MAR<=IR[27:0]; E1 cs=oe=1; E2 MBR<=mem_rdata; E3 AC<=MBR.
  - 0x2 STORE: E0 MAR<=IR[27:0], MBR<=AC; E1 cs=we=1, oe=0.
  - 0x3 ADD: as LOAD through E2; E3 alu_sel=ALU_ADD, AC<=alu_out.
  - 0x4 SUB: same as ADD with alu_sel=ALU_SUB (AC-MBR). Both wrap mod 2^32.
  - 0x5 SKIPCOND: E0 tests AC as signed two's complement; on a true condition PC<=PC+1 (wraps).
    - IR[27:26]=00: skip if AC<0.
    - 01: skip if AC==0.
    - 10: skip if AC>0.
    - 11: never skip.
  - 0x6 JUMP: E0 PC<=IR[27:0].
  - 0x7 CLEAR: E0 AC<=0.
  - 0xF HALT: E0 go to HALTED.
  - 0x8-0xE: E0 illegal_op<=1, go to HALTED. No instr_done pulse.
- instr_done asserts in the last execute state. The next cycle is F0 (or HALTED).
- Total cycles per instruction (F0 through last E):
  - LOAD / ADD / SUB: 8.
  - STORE: 6.
  - NOP / SKIPCOND / JUMP / CLEAR / HALT: 5.
- Never cs&we&oe simultaneously; we only in STORE E1.
- reset_n low mid-instruction: immediate return to reset values. Any in-flight write strobe drops asynchronously.

Decomposition:
- Package acc_cpu_pkg:
  - Opcode localparams OP_NOP..OP_HALT.
  - SKIPCOND codes.
  - ALU_ADD=4'b0010, ALU_SUB=4'b0011.
  - State enum: IDLE, F0, F1, F2, DECODE, E0, E1, E2, E3, HALTED.
- Sub-module acc_cpu_ctrl_decode: combinational state+opcode -> mem strobes, alu_sel and next state. Registers stay in the top module.

Test Plan:
- Reset: reset_n=0 with start=1 held -> state IDLE, pc_out=0x100, all strobes 0, running=0; nothing happens until reset_n=1 and start=1.
- LOAD/ADD/STORE/HALT:
  - Setup: M[0x110]=5, M[0x111]=7; program at 0x100: 0x10000110, 0x30000111, 0x20000112, 0xF0000000.
  - Expected: M[0x112]=12, AC=12, instr_done pulses 4 times, halted=1 exactly 27 cycles after the start-accept edge, pc_out=0x104.
- SUB/SKIPCOND:
  - Setup: AC=3, SUB M=5 -> AC=0xFFFFFFFE; SKIPCOND 0x50000000 skips the next JUMP.
  - Expected: PC advances by 2. SKIPCOND 0x54000000 with AC=0xFFFFFFFE does not skip.
- JUMP/PC wrap:
  - JUMP 0x0FFFFFFF, then a NOP fetched there -> pc_out=0x0000000 after fetch.
- Illegal opcode:
  - 0x90000000 -> HALTED, illegal_op=1, no instr_done.
  - start=1 -> illegal_op cleared, PC=0x100.
- Async reset mid-STORE: reset_n=0 during E1 -> mem_we falls in the same cycle, memory unchanged.
